// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: symbol constants, ordered-set encoding and scheduler state shared by the tx path
package pcie_phy_pkg;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  typedef enum logic [1:0] {OS_TS1, OS_TS2, OS_EIOS, OS_FTS} os_type_e;
  typedef enum logic [1:0] {IDLE, TS, DLLP2, TLP} sched_state_e;
  typedef logic [1:0] ts_beat_t;
endpackage

// File: rtl/tx_frame_scheduler_skp_timer.sv
// skp_timer: free-running interval counter raising a sticky skp_pending until cleared
module skp_timer #(
  parameter int INTERVAL = 1180,
  parameter int CW = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic pending
);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(INTERVAL - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      pending <= wrap | (pending & ~clr);
    end
  end
endmodule

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: arbitrates SKP, ordered sets, DLLPs and TLPs onto a framed x4 symbol beat
module tx_frame_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int MAX_TLP_WORDS = 1030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up,
  input  logic        os_req,
  input  logic [1:0]  os_type,
  input  logic [39:0] ts_fields,
  output logic        os_ack,
  input  logic        dllp_req,
  input  logic [47:0] dllp_data,
  output logic        dllp_ack,
  input  logic        tlp_valid,
  input  logic [31:0] tlp_data,
  input  logic        tlp_last,
  output logic        tlp_ready,
  output logic        tlp_underrun,
  output logic [7:0]  data_1,
  output logic [7:0]  data_2,
  output logic [7:0]  data_3,
  output logic [7:0]  data_4,
  output logic        k_1,
  output logic        k_2,
  output logic        k_3,
  output logic        k_4
);
  // counter is wide enough for the SKP interval, which must outlast the longest TLP
  localparam int CW = $clog2((SKP_INTERVAL > MAX_TLP_WORDS + 8) ? SKP_INTERVAL : MAX_TLP_WORDS + 9);
  sched_state_e state;
  ts_beat_t bi;
  os_type_e os_q;
  logic [15:0] ts_q;
  logic [23:0] dllp_q;
  logic [7:0] carry, id;
  logic rr_dllp, skp_pending, idle, os_is_ts;
  logic g_skp, g_os, g_dllp, g_tlp, dllp_el, tlp_el;
  logic [35:0] os_beat;
  logic [31:0] beat;
  logic [3:0] kf;
  skp_timer #(.INTERVAL(SKP_INTERVAL), .CW(CW)) u_skp (
    .clk(clk),
    .rst(rst),
    .clr(g_skp),
    .pending(skp_pending)
  );
  assign idle = state == IDLE;
  assign g_skp = idle & skp_pending;
  assign g_os = idle & ~skp_pending & os_req;
  assign dllp_el = idle & ~skp_pending & ~os_req & link_up & dllp_req;
  assign tlp_el = idle & ~skp_pending & ~os_req & link_up & tlp_valid;
  assign g_dllp = dllp_el & (~tlp_el | rr_dllp);
  assign g_tlp = tlp_el & (~dllp_el | ~rr_dllp);
  assign os_ack = ~rst & g_os;
  assign dllp_ack = ~rst & g_dllp;
  assign tlp_ready = ~rst & (g_tlp | state == TLP);
  assign tlp_underrun = ~rst & state == TLP & ~tlp_valid;
  assign os_is_ts = ~os_type[1];
  assign id = (os_q == OS_TS2) ? TS2_ID : TS1_ID;
  assign os_beat = os_type == OS_EIOS ? {COM, IDL, IDL, IDL, 4'hF} :
                   os_type == OS_FTS  ? {COM, FTS, FTS, FTS, 4'hF} :
                                        {COM, ts_fields[39:16], 4'h8};
  always_comb begin
    {beat, kf} = 36'h0;
    case (state)
      IDLE:  {beat, kf} = g_skp  ? {COM, SKP, SKP, SKP, 4'hF} :
                          g_os   ? os_beat :
                          g_dllp ? {SDP, dllp_data[47:24], 4'h8} :
                          g_tlp  ? {STP, tlp_data[31:8], 4'h8} : 36'h0;
      TS:    {beat, kf} = (bi == 2'd1) ? {ts_q, id, id, 4'h0} : {id, id, id, id, 4'h0};
      DLLP2: {beat, kf} = {dllp_q, END, 4'h1};
      TLP:   {beat, kf} = !tlp_valid ? {carry, 16'h0, EDB, 4'h1} :
                          tlp_last   ? {carry, tlp_data[31:16], END, 4'h1} :
                                       {carry, tlp_data[31:8], 4'h0};
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bi <= '0;
      os_q <= OS_TS1;
      ts_q <= '0;
      dllp_q <= '0;
      carry <= '0;
      rr_dllp <= 1'b1;
      {data_1, data_2, data_3, data_4, k_1, k_2, k_3, k_4} <= '0;
    end else begin
      {data_1, data_2, data_3, data_4, k_1, k_2, k_3, k_4} <= {beat, kf};
      case (state)
        IDLE: begin
          if (g_os && os_is_ts) begin
            state <= TS;
            bi <= 2'd1;
            ts_q <= ts_fields[15:0];
            os_q <= os_type_e'(os_type);
          end else if (g_dllp) begin
            state <= DLLP2;
            dllp_q <= dllp_data[23:0];
            rr_dllp <= 1'b0;
          end else if (g_tlp) begin
            state <= TLP;
            carry <= tlp_data[7:0];
            rr_dllp <= 1'b1;
          end
        end
        TS: begin
          bi <= bi + 2'd1;
          if (bi == 2'd3) state <= IDLE;
        end
        DLLP2: state <= IDLE;
        TLP: begin
          carry <= tlp_data[7:0];
          if (!tlp_valid || tlp_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
